// File: rtl/inst_queue_front.sv
// Instruction queue between fetch and issue: circular FIFO with decode-legality check,
// a RUN/TRAP state machine that stops issue after an illegal instruction, and a saturating illegal counter.
module inst_queue_front #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      io_enq_valid,
    output logic                      io_enq_ready,
    input  logic [XLEN-1:0]           io_enq_bits,
    output logic [XLEN-1:0]           io_inst,
    input  logic                      io_sigs_valid,
    output logic                      io_deq_valid,
    input  logic                      io_deq_ready,
    output logic [XLEN-1:0]           io_deq_bits,
    output logic                      io_deq_illegal,
    input  logic                      io_flush,
    output logic                      io_trap,
    output logic [$clog2(DEPTH):0]    io_count,
    output logic [7:0]                io_illegal_cnt
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_TRAP = 1'b1
    } state_e;

    logic [XLEN-1:0] mem_q [DEPTH];
    logic [AW-1:0]   head_q, head_d;
    logic [AW-1:0]   tail_q, tail_d;
    logic [AW:0]     count_q, count_d;
    state_e          state_q, state_d;
    logic [7:0]      ill_cnt_q, ill_cnt_d;
    logic            head_valid_s;
    logic            enq_fire_s;
    logic            deq_fire_s;

    // Handshake and head presentation; storage is only visible while the queue holds an entry.
    always_comb begin
        head_valid_s   = (count_q != {(AW + 1){1'b0}});
        io_enq_ready   = (count_q != FULL_CNT) && !io_flush;
        io_deq_valid   = head_valid_s && (state_q == ST_RUN) && !io_flush;
        io_deq_illegal = io_deq_valid && !io_sigs_valid;
        enq_fire_s     = io_enq_valid && io_enq_ready;
        deq_fire_s     = io_deq_valid && io_deq_ready;
        if (head_valid_s) begin
            io_inst     = mem_q[head_q];
            io_deq_bits = mem_q[head_q];
        end else begin
            io_inst     = {XLEN{1'b0}};
            io_deq_bits = {XLEN{1'b0}};
        end
    end

    // Next-state computation; flush overrides any same-cycle transfer but keeps the illegal count.
    always_comb begin
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        state_d   = state_q;
        ill_cnt_d = ill_cnt_q;
        if (io_flush) begin
            head_d  = {AW{1'b0}};
            tail_d  = {AW{1'b0}};
            count_d = {(AW + 1){1'b0}};
            state_d = ST_RUN;
        end else begin
            if (enq_fire_s) begin
                tail_d = tail_q + AW'(1);
            end else begin
                tail_d = tail_q;
            end
            if (deq_fire_s) begin
                head_d = head_q + AW'(1);
            end else begin
                head_d = head_q;
            end
            case ({enq_fire_s, deq_fire_s})
                2'b10:   count_d = count_q + (AW + 1)'(1);
                2'b01:   count_d = count_q - (AW + 1)'(1);
                default: count_d = count_q;
            endcase
            case (state_q)
                ST_RUN: begin
                    if (deq_fire_s && io_deq_illegal) begin
                        state_d = ST_TRAP;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_TRAP: state_d = ST_TRAP;
                default: state_d = ST_RUN;
            endcase
            if (deq_fire_s && io_deq_illegal && (ill_cnt_q != 8'hFF)) begin
                ill_cnt_d = ill_cnt_q + 8'd1;
            end else begin
                ill_cnt_d = ill_cnt_q;
            end
        end
    end

    // Control state registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q    <= {AW{1'b0}};
            tail_q    <= {AW{1'b0}};
            count_q   <= {(AW + 1){1'b0}};
            state_q   <= ST_RUN;
            ill_cnt_q <= 8'd0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            state_q   <= state_d;
            ill_cnt_q <= ill_cnt_d;
        end
    end

    // Entry storage is not reset; the head mux hides stale contents.
    always_ff @(posedge clk) begin
        if (enq_fire_s) begin
            mem_q[tail_q] <= io_enq_bits;
        end
    end

    assign io_count       = count_q;
    assign io_trap        = (state_q == ST_TRAP);
    assign io_illegal_cnt = ill_cnt_q;

endmodule

// File: doc/inst_queue_front.md
INST_QUEUE_FRONT -- requirements
Module: inst_queue_front

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning queue entries (power of two, 2..16).
REQ-002 The block SHALL have parameter XLEN, default 32, meaning instruction width.
REQ-003 The block SHALL have port clk, input, 1, meaning the single clock; all state SHALL be clocked on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, meaning asynchronous active-low reset: asserted at 0, released at 1.
REQ-005 The block SHALL have port io_enq_valid, input, 1, meaning the fetch stage offers an instruction.
REQ-006 The block SHALL have port io_enq_ready, output, 1, meaning the queue accepts an instruction this cycle.
REQ-007 The block SHALL have port io_enq_bits, input, XLEN, meaning the offered instruction word.
REQ-008 The block SHALL have port io_inst, output, XLEN, meaning the head instruction driven to the combinational decoder.
REQ-009 The block SHALL have port io_sigs_valid, input, 1, meaning the decoder reports io_inst as legal.
REQ-010 The block SHALL have port io_deq_valid, output, 1, meaning a decoded head instruction is offered to issue.
REQ-011 The block SHALL have port io_deq_ready, input, 1, meaning issue accepts the head instruction.
REQ-012 The block SHALL have port io_deq_bits, output, XLEN, meaning the head instruction word.
REQ-013 The block SHALL have port io_deq_illegal, output, 1, meaning the offered head instruction is illegal.
REQ-014 The block SHALL have port io_flush, input, 1, meaning discard all queued instructions and leave TRAP.
REQ-015 The block SHALL have port io_trap, output, 1, meaning the block is in TRAP state.
REQ-016 The block SHALL have port io_count, output, log2(DEPTH)+1, meaning current occupancy.
REQ-017 The block SHALL have port io_illegal_cnt, output, 8, meaning the saturating count of illegal instructions dequeued.

Function
REQ-018 The block SHALL implement a circular FIFO of DEPTH entries using head and tail pointers that wrap modulo DEPTH and a separate occupancy count.
REQ-019 The block SHALL drive io_enq_ready = (io_count != DEPTH) && !io_flush; enqueue fires on io_enq_valid && io_enq_ready.
REQ-020 The block SHALL provide no enqueue-to-dequeue bypass: an instruction enqueued at edge N appears at the head no earlier than the cycle after edge N, giving a minimum latency of 1 cycle.
REQ-021 The block SHALL drive io_inst and io_deq_bits with the head entry when io_count > 0, and with 0 otherwise.
REQ-022 The block SHALL drive io_deq_valid = (io_count > 0) && (state == RUN) && !io_flush.
REQ-023 The block SHALL drive io_deq_illegal = io_deq_valid && !io_sigs_valid, combinationally within the same cycle.
REQ-024 Dequeue SHALL fire on io_deq_valid && io_deq_ready and SHALL advance the head pointer.
REQ-025 A simultaneous enqueue and dequeue SHALL leave io_count unchanged and advance both pointers.
REQ-026 The state machine SHALL have two states, RUN and TRAP; RUN SHALL go to TRAP on a dequeue fire with io_deq_illegal=1.
REQ-027 TRAP SHALL go to RUN only on io_flush=1; in TRAP, io_deq_valid SHALL be 0, and enqueue SHALL continue while not full.
REQ-028 io_trap SHALL be 1 exactly when the state is TRAP.
REQ-029 io_flush SHALL take priority over enqueue and dequeue in the same cycle: at the next edge, pointers=0, io_count=0, and state=RUN; io_illegal_cnt SHALL be unchanged.
REQ-030 io_illegal_cnt SHALL increment by 1 on each illegal dequeue fire and SHALL saturate at 255 without wrapping.
REQ-031 When io_deq_valid=0, the block SHALL ignore io_deq_ready; when io_enq_ready=0, it SHALL ignore io_enq_valid.

Reset
REQ-032 While reset=0, the block SHALL asynchronously clear the pointers, io_count (0), state (RUN) and io_illegal_cnt (0), independent of clk.
REQ-033 During and immediately after reset, outputs SHALL be: io_enq_ready=1, io_deq_valid=0, io_deq_illegal=0, io_trap=0, io_inst=0, io_deq_bits=0.
REQ-034 Storage array contents need not be reset; they SHALL never be visible because of REQ-021.
REQ-035 Assertion of reset mid-transfer SHALL discard all queued entries with no partial dequeue.

Verification
REQ-036 Scenario: enqueue 32'h00000013 with io_sigs_valid=1 and io_deq_ready=1 -> io_deq_valid rises 1 cycle later with io_deq_bits=32'h00000013 and io_deq_illegal=0, then io_count returns to 0.
REQ-037 Scenario: with io_deq_ready=0, enqueue 5 words (DEPTH=4) -> io_count=4, io_enq_ready=0 after the 4th, 5th word not accepted; drain -> words appear in order and pointers wrap correctly.
REQ-038 Scenario: head has io_sigs_valid=0 and io_deq_ready=1 -> one illegal fire, io_illegal_cnt=1, io_trap=1 next cycle, io_deq_valid=0 while 2 entries remain; io_flush -> io_count=0, io_trap=0, io_illegal_cnt stays 1.
REQ-039 Scenario: at full, assert io_flush together with io_enq_valid -> io_enq_ready=0 and io_count=0 next cycle; with io_count=2, simultaneous enqueue and dequeue -> io_count stays 2.
REQ-040 Scenario: 300 illegal dequeues, each followed by a flush -> io_illegal_cnt=255.
REQ-041 Scenario: pull reset low between clock edges with 3 entries queued -> outputs reach REQ-033 values immediately, with no clock edge.
